// File: rtl/ads1292_frame_packer.sv
// ads1292_frame_packer
// Captures 72-bit RDATAC frames from the ADS1292 controller, checks the
// status header, holds one pending frame and streams each accepted frame
// out as a 9-byte packet (SYNC, SEQ, CH1 x3, CH2 x3, CHK) over a
// valid/ready byte interface.
module ads1292_frame_packer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [71:0]      i_frame,
  input  logic             i_frame_valid,
  input  logic             i_enable,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  input  logic             i_byte_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_hdr_err_cnt,
  output logic [7:0]       o_seq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Checksum over SEQ and the six channel bytes; SYNC is not covered.
  function automatic logic [7:0] chk_calc(input logic [7:0] seq, input logic [47:0] data);
    chk_calc = seq ^ data[47:40] ^ data[39:32] ^ data[31:24]
                   ^ data[23:16] ^ data[15:8]  ^ data[7:0];
  endfunction

  logic [0:0]       state_q, state_d;
  logic             buf_full_q, buf_full_d;
  logic [47:0]      buf_data_q, buf_data_d;
  logic [63:0]      shreg_q, shreg_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] hdr_q, hdr_d;
  logic [7:0]       seq_q, seq_d;

  logic xfer_s;
  logic last_s;
  logic load_s;
  logic cap_s;
  logic good_s;
  logic unused_status_s;

  assign xfer_s = valid_q & i_byte_ready;
  assign last_s = (idx_q == 4'd8);
  // A buffered frame is loaded either from IDLE or right after CHK leaves,
  // which gives back-to-back packets without an idle cycle.
  assign load_s = buf_full_q & ((state_q == ST_IDLE) |
                                ((state_q == ST_SEND) & xfer_s & last_s));
  assign cap_s  = i_frame_valid & i_enable;
  assign good_s = (i_frame[71:68] == 4'hC);
  // Only the top status nibble is checked; the rest of the status word is dropped.
  assign unused_status_s = ^i_frame[67:48];

  // Next-state logic: packet sequencing, frame capture and counters.
  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    hdr_d      = hdr_q;
    seq_d      = seq_q;

    // Output side: load a new packet or advance through the current one.
    if (load_s) begin
      shreg_d    = {seq_q, buf_data_q, chk_calc(seq_q, buf_data_q)};
      byte_d     = SYNC_BYTE;
      valid_d    = 1'b1;
      idx_d      = 4'd0;
      state_d    = ST_SEND;
      seq_d      = seq_q + 8'd1;
      buf_full_d = 1'b0;
    end else if ((state_q == ST_SEND) && xfer_s) begin
      if (last_s) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        byte_d  = 8'h00;
        idx_d   = 4'd0;
      end else begin
        byte_d  = shreg_q[63:56];
        shreg_d = {shreg_q[55:0], 8'h00};
        idx_d   = idx_q + 4'd1;
      end
    end else begin
      // Stalled or idle: o_byte holds its value.
      state_d = state_q;
    end

    // Input side: a buffer freed by this cycle's load can take the new frame.
    if (cap_s) begin
      if (!good_s) begin
        if (hdr_q != CNT_MAX) begin
          hdr_d = hdr_q + CNT_ONE;
        end else begin
          hdr_d = hdr_q;
        end
      end else if (!buf_full_q || load_s) begin
        buf_data_d = i_frame[47:0];
        buf_full_d = 1'b1;
      end else begin
        if (drop_q != CNT_MAX) begin
          drop_d = drop_q + CNT_ONE;
        end else begin
          drop_d = drop_q;
        end
      end
    end else begin
      buf_data_d = buf_data_d;
    end

    busy_d = (state_d == ST_SEND) | buf_full_d;
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
      buf_data_q <= 48'h0;
      shreg_q    <= 64'h0;
      idx_q      <= 4'd0;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= {CNT_W{1'b0}};
      hdr_q      <= {CNT_W{1'b0}};
      seq_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      hdr_q      <= hdr_d;
      seq_q      <= seq_d;
    end
  end

  assign o_byte        = byte_q;
  assign o_byte_valid  = valid_q;
  assign o_busy        = busy_q;
  assign o_drop_cnt    = drop_q;
  assign o_hdr_err_cnt = hdr_q;
  assign o_seq         = seq_q;

endmodule

// File: tb/tb_ads1292_frame_packer.sv
// Directed bench for ads1292_frame_packer: expected packet bytes are queued
// when frames are driven and compared as the DUT hands bytes over.
module tb_ads1292_frame_packer;

  logic        clk;
  logic        rstn;
  logic [71:0] i_frame;
  logic        i_frame_valid;
  logic        i_enable;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;
  logic [7:0]  o_hdr_err_cnt;
  logic [7:0]  o_seq;

  int          n_assert;
  int          n_fail;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_seq;
  logic        stalled;
  logic [7:0]  stall_byte;

  ads1292_frame_packer dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_frame       (i_frame),
    .i_frame_valid (i_frame_valid),
    .i_enable      (i_enable),
    .o_byte        (o_byte),
    .o_byte_valid  (o_byte_valid),
    .i_byte_ready  (i_byte_ready),
    .o_busy        (o_busy),
    .o_drop_cnt    (o_drop_cnt),
    .o_hdr_err_cnt (o_hdr_err_cnt),
    .o_seq         (o_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_chk(input logic [7:0] s, input logic [23:0] a, input logic [23:0] b);
    pkt_chk = s ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ b[23:16] ^ b[15:8] ^ b[7:0];
  endfunction

  task automatic push_pkt(input logic [7:0] s, input logic [23:0] a, input logic [23:0] b);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(b[23:16]);
    exp_q.push_back(b[15:8]);
    exp_q.push_back(b[7:0]);
    exp_q.push_back(pkt_chk(s, a, b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [23:0] st, input logic [23:0] a, input logic [23:0] b, input logic en);
    i_frame       = {st, a, b};
    i_enable      = en;
    i_frame_valid = 1'b1;
    tick();
    i_frame_valid = 1'b0;
    i_enable      = 1'b1;
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || o_busy || o_byte_valid) && cyc < budget) begin
      tick();
      cyc++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && !o_busy && !o_byte_valid)}, 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    exp_q.delete();
    exp_seq = 8'h00;
    rstn = 1'b1;
    tick();
  endtask

  // Monitor: scoreboard compare on each handshake and hold check while stalled.
  always @(negedge clk) begin
    if (!rstn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", {31'd0, o_byte_valid}, 32'd1);
        check("hold_byte", {24'd0, o_byte}, {24'd0, stall_byte});
      end
      if (o_byte_valid && i_byte_ready) begin
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_byte: observed %0h expected none", o_byte);
        end
        if (exp_q.size() != 0) check("byte", {24'd0, o_byte}, {24'd0, exp_q.pop_front()});
      end
      stalled    = o_byte_valid && !i_byte_ready;
      stall_byte = o_byte;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] c1;
    logic [23:0] c2;
    int          cyc;
    n_assert      = 0;
    n_fail        = 0;
    exp_seq       = 8'h00;
    stalled       = 1'b0;
    stall_byte    = 8'h00;
    rstn          = 1'b0;
    i_frame       = 72'h0;
    i_frame_valid = 1'b0;
    i_enable      = 1'b1;
    i_byte_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid", {31'd0, o_byte_valid}, 32'd0);
    check("rst_byte",  {24'd0, o_byte}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_drop",  {24'd0, o_drop_cnt}, 32'd0);
    check("rst_hdr",   {24'd0, o_hdr_err_cnt}, 32'd0);
    check("rst_seq",   {24'd0, o_seq}, 32'd0);
    rstn = 1'b1;
    tick();

    // T2: single frame, known bytes, latency
    i_byte_ready = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD); exp_q.push_back(8'hEF); exp_q.push_back(8'hF9);
    i_frame       = {24'hC00000, 24'h123456, 24'hABCDEF};
    i_frame_valid = 1'b1;
    tick();
    i_frame_valid = 1'b0;
    check("t2_lat_valid0", {31'd0, o_byte_valid}, 32'd0);
    check("t2_lat_busy",   {31'd0, o_busy}, 32'd1);
    tick();
    check("t2_lat_valid1", {31'd0, o_byte_valid}, 32'd1);
    check("t2_first_byte", {24'd0, o_byte}, 32'hA5);
    drain(50);
    check("t2_seq", {24'd0, o_seq}, 32'd1);

    // T1: reset in the middle of a stalled packet
    i_byte_ready = 1'b0;
    pulse(24'hC00000, 24'h111111, 24'h222222, 1'b1);
    repeat (3) tick();
    check("t1_pre_valid", {31'd0, o_byte_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    check("t1_valid", {31'd0, o_byte_valid}, 32'd0);
    check("t1_byte",  {24'd0, o_byte}, 32'd0);
    check("t1_busy",  {31'd0, o_busy}, 32'd0);
    check("t1_seq",   {24'd0, o_seq}, 32'd0);
    check("t1_drop",  {24'd0, o_drop_cnt}, 32'd0);
    check("t1_hdr",   {24'd0, o_hdr_err_cnt}, 32'd0);
    exp_q.delete();
    exp_seq = 8'h00;
    tick();
    rstn = 1'b1;
    i_byte_ready = 1'b1;
    repeat (12) tick();
    check("t1_post_valid", {31'd0, o_byte_valid}, 32'd0);
    check("t1_post_busy",  {31'd0, o_busy}, 32'd0);

    // T3: random backpressure, same bytes as T2
    do_reset();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD); exp_q.push_back(8'hEF); exp_q.push_back(8'hF9);
    pulse(24'hC00000, 24'h123456, 24'hABCDEF, 1'b1);
    cyc = 0;
    while ((exp_q.size() != 0) && cyc < 300) begin
      i_byte_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    i_byte_ready = 1'b1;
    drain(50);
    check("t3_seq", {24'd0, o_seq}, 32'd1);

    // T4: overflow with sink stalled, then back-to-back drain
    do_reset();
    i_byte_ready = 1'b0;
    pulse(24'hC00000, 24'h0A0B0C, 24'h0D0E0F, 1'b1);
    repeat (3) tick();
    pulse(24'hC12345, 24'h102030, 24'h405060, 1'b1);
    pulse(24'hC00000, 24'h777777, 24'h888888, 1'b1);
    check("t4_drop", {24'd0, o_drop_cnt}, 32'd1);
    check("t4_busy", {31'd0, o_busy}, 32'd1);
    push_pkt(8'h00, 24'h0A0B0C, 24'h0D0E0F);
    push_pkt(8'h01, 24'h102030, 24'h405060);
    i_byte_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("t4_b2b_valid", {31'd0, o_byte_valid}, 32'd1);
    end
    @(negedge clk);
    check("t4_end_valid", {31'd0, o_byte_valid}, 32'd0);
    tick();
    drain(10);
    check("t4_seq", {24'd0, o_seq}, 32'd2);

    // T4b: new frame arriving on the cycle the buffer is freed is kept
    pulse(24'hC00000, 24'h135790, 24'h2468AC, 1'b1);
    pulse(24'hC00000, 24'hFEDCBA, 24'h987654, 1'b1);
    push_pkt(8'h02, 24'h135790, 24'h2468AC);
    push_pkt(8'h03, 24'hFEDCBA, 24'h987654);
    drain(60);
    check("t4b_drop", {24'd0, o_drop_cnt}, 32'd1);

    // T5: bad headers and disabled capture
    do_reset();
    i_byte_ready = 1'b1;
    pulse(24'h800000, 24'h123456, 24'hABCDEF, 1'b1);
    repeat (5) tick();
    check("t5_hdr1",  {24'd0, o_hdr_err_cnt}, 32'd1);
    check("t5_valid", {31'd0, o_byte_valid}, 32'd0);
    check("t5_busy",  {31'd0, o_busy}, 32'd0);
    i_byte_ready = 1'b0;
    pulse(24'hC00000, 24'h314159, 24'h265358, 1'b1);
    pulse(24'hC00000, 24'h979323, 24'h846264, 1'b1);
    pulse(24'h400000, 24'h338327, 24'h950288, 1'b1);
    check("t5_hdr2",  {24'd0, o_hdr_err_cnt}, 32'd2);
    check("t5_drop0", {24'd0, o_drop_cnt}, 32'd0);
    pulse(24'hC00000, 24'h555555, 24'h666666, 1'b0);
    pulse(24'h000000, 24'h555555, 24'h666666, 1'b0);
    check("t5_en_hdr",  {24'd0, o_hdr_err_cnt}, 32'd2);
    check("t5_en_drop", {24'd0, o_drop_cnt}, 32'd0);
    push_pkt(8'h00, 24'h314159, 24'h265358);
    push_pkt(8'h01, 24'h979323, 24'h846264);
    i_enable     = 1'b0;
    i_byte_ready = 1'b1;
    drain(80);
    i_enable     = 1'b1;
    check("t5_seq", {24'd0, o_seq}, 32'd2);

    // T6: SEQ wrap after 256 packets, then drop counter saturation
    do_reset();
    i_byte_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      c1 = 24'($urandom);
      c2 = 24'($urandom);
      pulse({4'hC, 20'($urandom)}, c1, c2, 1'b1);
      push_pkt(exp_seq, c1, c2);
      exp_seq = exp_seq + 8'd1;
      drain(40);
    end
    check("t6_seq_wrap", {24'd0, o_seq}, 32'd0);
    c1 = 24'h0F1E2D;
    c2 = 24'h3C4B5A;
    pulse(24'hC00000, c1, c2, 1'b1);
    push_pkt(8'h00, c1, c2);
    exp_seq = 8'h01;
    drain(40);
    i_byte_ready = 1'b0;
    for (int k = 0; k < 260; k++) begin
      c1 = 24'($urandom);
      c2 = 24'($urandom);
      pulse(24'hC00000, c1, c2, 1'b1);
      if (k < 2) begin
        push_pkt(exp_seq, c1, c2);
        exp_seq = exp_seq + 8'd1;
      end
    end
    check("t6_drop_sat", {24'd0, o_drop_cnt}, 32'hFF);
    i_byte_ready = 1'b1;
    drain(100);
    check("t6_drop_hold", {24'd0, o_drop_cnt}, 32'hFF);
    check("t6_hdr", {24'd0, o_hdr_err_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
